decode_execute_stage: RTL and testbench

Y86-64 pipeline decode stage plus the D→E pipeline register. It consumes the D-register outputs and performs register-ID selection and the 15×64-bit register-file read. It applies forwarding from the E/M/W stages and latches the result into the E register for the execute stage. Writeback also lands here, because the register file lives in this block.

---
 rtl/decode_execute_stage.sv | 210 +++++++++++++++++++++
 tb/tb_decode_execute_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// Y86-64 decode: register-ID select, 15x64 register file (with writeback), operand forwarding, D->E register.
// Latency: one cycle D->E; d_srcA/d_srcB are combinational. Backpressure: E_tostall holds E, E_toBubble injects a nop.
// DECODE_FORWARD_EN enables the E/M/W forwarding chain; otherwise the file bypasses W writes and hazards must stall.
module decode_execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  D_stat,
    input  logic [3:0]  D_Ins_Code,
    input  logic [3:0]  D_Ins_fun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_Val_C,
    input  logic [63:0] D_Val_P,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_Val_E,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_Val_E,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_Val_M,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_Val_E,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_Val_M,
    input  logic        E_toBubble,
    input  logic        E_tostall,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [2:0]  E_stat,
    output logic [3:0]  E_Ins_Code,
    output logic [3:0]  E_Ins_fun,
    output logic [63:0] E_Val_C,
    output logic [63:0] E_Val_A,
    output logic [63:0] E_Val_B,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] INOP  = 4'h1;

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b, val_a, val_b;
    logic [63:0] reg_q [0:14];
    logic [63:0] reg_d [0:14];

    logic [2:0]  e_stat_q, e_stat_d;
    logic [3:0]  e_icode_q, e_icode_d, e_ifun_q, e_ifun_d;
    logic [63:0] e_valc_q, e_valc_d, e_vala_q, e_vala_d, e_valb_q, e_valb_d;
    logic [3:0]  e_dste_q, e_dste_d, e_dstm_q, e_dstm_d;
    logic [3:0]  e_srca_q, e_srca_d, e_srcb_q, e_srcb_d;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_Ins_Code)
            4'h2: begin src_a = D_rA; dst_e = D_rB; end
            4'h3: dst_e = D_rB;
            4'h4: begin src_a = D_rA; src_b = D_rB; end
            4'h5: begin src_b = D_rB; dst_m = D_rA; end
            4'h6: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // Register-file read; without forwarding, W results are bypassed here instead.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (src_a != RNONE) begin
            rf_a = reg_q[src_a];
`ifndef DECODE_FORWARD_EN
            if (src_a == W_dstM)      rf_a = W_Val_M;
            else if (src_a == W_dstE) rf_a = W_Val_E;
`endif
        end
        if (src_b != RNONE) begin
            rf_b = reg_q[src_b];
`ifndef DECODE_FORWARD_EN
            if (src_b == W_dstM)      rf_b = W_Val_M;
            else if (src_b == W_dstE) rf_b = W_Val_E;
`endif
        end
    end

    always_comb begin
        val_a = rf_a;
        val_b = rf_b;
`ifdef DECODE_FORWARD_EN
        if (src_a != RNONE) begin
            if (src_a == e_dstE)      val_a = e_Val_E;
            else if (src_a == M_dstM) val_a = m_Val_M;
            else if (src_a == M_dstE) val_a = M_Val_E;
            else if (src_a == W_dstM) val_a = W_Val_M;
            else if (src_a == W_dstE) val_a = W_Val_E;
        end
        if (src_b != RNONE) begin
            if (src_b == e_dstE)      val_b = e_Val_E;
            else if (src_b == M_dstM) val_b = m_Val_M;
            else if (src_b == M_dstE) val_b = M_Val_E;
            else if (src_b == W_dstM) val_b = W_Val_M;
            else if (src_b == W_dstE) val_b = W_Val_E;
        end
`endif
        // call/jXX carry valP down the pipe in valA, overriding any forward.
        if (D_Ins_Code == 4'h7 || D_Ins_Code == 4'h8) val_a = D_Val_P;
    end

`ifndef DECODE_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_Val_E, M_dstE, M_Val_E, M_dstM, m_Val_M};
`endif

    // dstM is applied after dstE so a load result wins a same-register collision.
    always_comb begin
        for (int i = 0; i < 15; i++) reg_d[i] = reg_q[i];
        if (W_dstE != RNONE) reg_d[W_dstE] = W_Val_E;
        if (W_dstM != RNONE) reg_d[W_dstM] = W_Val_M;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            if (rst) reg_q[i] <= '0;
            else     reg_q[i] <= reg_d[i];
        end
    end

    always_comb begin
        e_stat_d  = e_stat_q;
        e_icode_d = e_icode_q;
        e_ifun_d  = e_ifun_q;
        e_valc_d  = e_valc_q;
        e_vala_d  = e_vala_q;
        e_valb_d  = e_valb_q;
        e_dste_d  = e_dste_q;
        e_dstm_d  = e_dstm_q;
        e_srca_d  = e_srca_q;
        e_srcb_d  = e_srcb_q;
        if (E_toBubble) begin
            e_stat_d  = '0;
            e_icode_d = INOP;
            e_ifun_d  = '0;
            e_valc_d  = '0;
            e_vala_d  = '0;
            e_valb_d  = '0;
            e_dste_d  = RNONE;
            e_dstm_d  = RNONE;
            e_srca_d  = RNONE;
            e_srcb_d  = RNONE;
        end else if (!E_tostall) begin
            e_stat_d  = D_stat;
            e_icode_d = D_Ins_Code;
            e_ifun_d  = D_Ins_fun;
            e_valc_d  = D_Val_C;
            e_vala_d  = val_a;
            e_valb_d  = val_b;
            e_dste_d  = dst_e;
            e_dstm_d  = dst_m;
            e_srca_d  = src_a;
            e_srcb_d  = src_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_stat_q  <= '0;
            e_icode_q <= INOP;
            e_ifun_q  <= '0;
            e_valc_q  <= '0;
            e_vala_q  <= '0;
            e_valb_q  <= '0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
            e_srca_q  <= RNONE;
            e_srcb_q  <= RNONE;
        end else begin
            e_stat_q  <= e_stat_d;
            e_icode_q <= e_icode_d;
            e_ifun_q  <= e_ifun_d;
            e_valc_q  <= e_valc_d;
            e_vala_q  <= e_vala_d;
            e_valb_q  <= e_valb_d;
            e_dste_q  <= e_dste_d;
            e_dstm_q  <= e_dstm_d;
            e_srca_q  <= e_srca_d;
            e_srcb_q  <= e_srcb_d;
        end
    end

    assign E_stat     = e_stat_q;
    assign E_Ins_Code = e_icode_q;
    assign E_Ins_fun  = e_ifun_q;
    assign E_Val_C    = e_valc_q;
    assign E_Val_A    = e_vala_q;
    assign E_Val_B    = e_valb_q;
    assign E_dstE     = e_dste_q;
    assign E_dstM     = e_dstm_q;
    assign E_srcA     = e_srca_q;
    assign E_srcB     = e_srcb_q;
endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: directed scenarios plus randomized traffic against an architectural model.
module tb_decode_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  D_stat;
    logic [3:0]  D_Ins_Code, D_Ins_fun, D_rA, D_rB;
    logic [63:0] D_Val_C, D_Val_P;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_Val_E, M_Val_E, m_Val_M, W_Val_E, W_Val_M;
    logic        E_toBubble, E_tostall;
    logic [3:0]  d_srcA, d_srcB;
    logic [2:0]  E_stat;
    logic [3:0]  E_Ins_Code, E_Ins_fun;
    logic [63:0] E_Val_C, E_Val_A, E_Val_B;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valc, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb;
    } e_t;

    e_t          model_e;
    logic [63:0] model_rf [15];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    always #5 clk = ~clk;

    decode_execute_stage dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_Ins_Code(D_Ins_Code), .D_Ins_fun(D_Ins_fun),
        .D_rA(D_rA), .D_rB(D_rB), .D_Val_C(D_Val_C), .D_Val_P(D_Val_P),
        .e_dstE(e_dstE), .e_Val_E(e_Val_E),
        .M_dstE(M_dstE), .M_Val_E(M_Val_E), .M_dstM(M_dstM), .m_Val_M(m_Val_M),
        .W_dstE(W_dstE), .W_Val_E(W_Val_E), .W_dstM(W_dstM), .W_Val_M(W_Val_M),
        .E_toBubble(E_toBubble), .E_tostall(E_tostall),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_Ins_Code(E_Ins_Code), .E_Ins_fun(E_Ins_fun),
        .E_Val_C(E_Val_C), .E_Val_A(E_Val_A), .E_Val_B(E_Val_B),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    function automatic void decode_ids(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                       output logic [3:0] sa, output logic [3:0] sb,
                                       output logic [3:0] de, output logic [3:0] dm);
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        de = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    // Youngest in-flight producer of a register wins; W values reach decode either way.
    function automatic logic [63:0] operand(input logic [3:0] id);
        logic [3:0]  ids[$];
        logic [63:0] vals[$];
        logic [63:0] r;
        bit          hit;
`ifdef DECODE_FORWARD_EN
        ids  = {e_dstE, M_dstM, M_dstE};
        vals = {e_Val_E, m_Val_M, M_Val_E};
`endif
        ids.push_back(W_dstM);  vals.push_back(W_Val_M);
        ids.push_back(W_dstE);  vals.push_back(W_Val_E);
        if (id == 4'hF) return 64'd0;
        hit = 1'b0;
        r = model_rf[id];
        foreach (ids[i]) if (!hit && ids[i] == id) begin r = vals[i]; hit = 1'b1; end
        return r;
    endfunction

    function automatic e_t model_next();
        e_t n;
        logic [3:0] sa, sb, de, dm;
        if (rst || E_toBubble) begin
            n = '0;
            n.icode = 4'h1;
            n.dste = 4'hF; n.dstm = 4'hF; n.srca = 4'hF; n.srcb = 4'hF;
        end else if (E_tostall) begin
            n = model_e;
        end else begin
            decode_ids(D_Ins_Code, D_rA, D_rB, sa, sb, de, dm);
            n.stat = D_stat; n.icode = D_Ins_Code; n.ifun = D_Ins_fun; n.valc = D_Val_C;
            n.vala = (D_Ins_Code == 4'h7 || D_Ins_Code == 4'h8) ? D_Val_P : operand(sa);
            n.valb = operand(sb);
            n.dste = de; n.dstm = dm; n.srca = sa; n.srcb = sb;
        end
        return n;
    endfunction

    task automatic tick();
        e_t n;
        n = model_next();
        @(posedge clk);
        model_e = n;
        if (rst) begin
            foreach (model_rf[i]) model_rf[i] = 64'd0;
        end else begin
            if (W_dstE != 4'hF) model_rf[W_dstE] = W_Val_E;
            if (W_dstM != 4'hF) model_rf[W_dstM] = W_Val_M;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; E_toBubble = 1'b0; E_tostall = 1'b0;
        D_stat = 3'd0; D_Ins_Code = 4'h1; D_Ins_fun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_Val_C = 64'd0; D_Val_P = 64'd0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_Val_E = 64'd0; M_Val_E = 64'd0; m_Val_M = 64'd0; W_Val_E = 64'd0; W_Val_M = 64'd0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        D_Ins_Code = ic; D_rA = ra; D_rB = rb;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        W_dstE = 4'h3; W_Val_E = 64'hDEAD;
        tick();
        idle();
        chk_cnt++; if (E_Ins_Code !== 4'h1) $display("FAIL reset_icode got %h want 1", E_Ins_Code); else pass_cnt++;
        chk_cnt++; if (E_dstE !== 4'hF) $display("FAIL reset_dstE got %h want f", E_dstE); else pass_cnt++;
        chk_cnt++; if (E_Val_A !== 64'd0) $display("FAIL reset_valA got %h want 0", E_Val_A); else pass_cnt++;
        set_d(4'h2, 4'h3, 4'h1);
        tick();
        chk_cnt++; if (E_Val_A !== 64'd0) $display("FAIL reset_reg3 got %h want 0", E_Val_A); else pass_cnt++;
    endtask

    task automatic test_writeback_read();
        idle();
        W_dstE = 4'h3; W_Val_E = 64'h55;
        tick();
        idle();
        set_d(4'h2, 4'h3, 4'h7);
        tick();
        chk_cnt++; if (E_Val_A !== 64'h55) $display("FAIL wb_read_valA got %h want 55", E_Val_A); else pass_cnt++;
        chk_cnt++; if (E_dstE !== 4'h7) $display("FAIL wb_read_dstE got %h want 7", E_dstE); else pass_cnt++;
        chk_cnt++; if (E_Ins_Code !== 4'h2) $display("FAIL wb_read_icode got %h want 2", E_Ins_Code); else pass_cnt++;
    endtask

    task automatic test_forward_priority();
        logic [63:0] want;
        idle();
        W_dstE = 4'h2; W_Val_E = 64'h99;
        tick();
        idle();
        set_d(4'h6, 4'h2, 4'h1);
        e_dstE = 4'h2; e_Val_E = 64'h11;
        M_dstE = 4'h2; M_Val_E = 64'h22;
        #1;
        chk_cnt++; if (d_srcA !== 4'h2) $display("FAIL fwd_srcA got %h want 2", d_srcA); else pass_cnt++;
        tick();
`ifdef DECODE_FORWARD_EN
        want = 64'h11;
`else
        want = 64'h99;
`endif
        chk_cnt++; if (E_Val_A !== want) $display("FAIL fwd_e_over_M got %h want %h", E_Val_A, want); else pass_cnt++;
        e_dstE = 4'hF;
        tick();
`ifdef DECODE_FORWARD_EN
        want = 64'h22;
`else
        want = 64'h99;
`endif
        chk_cnt++; if (E_Val_A !== want) $display("FAIL fwd_M_when_e_none got %h want %h", E_Val_A, want); else pass_cnt++;
    endtask

    task automatic test_popq();
        idle();
        set_d(4'hB, 4'h5, 4'hF);
        #1;
        chk_cnt++; if (d_srcA !== 4'h4) $display("FAIL popq_srcA got %h want 4", d_srcA); else pass_cnt++;
        chk_cnt++; if (d_srcB !== 4'h4) $display("FAIL popq_srcB got %h want 4", d_srcB); else pass_cnt++;
        tick();
        chk_cnt++; if (E_dstE !== 4'h4) $display("FAIL popq_dstE got %h want 4", E_dstE); else pass_cnt++;
        chk_cnt++; if (E_dstM !== 4'h5) $display("FAIL popq_dstM got %h want 5", E_dstM); else pass_cnt++;
    endtask

    task automatic test_call();
        idle();
        set_d(4'h8, 4'hF, 4'hF);
        D_Val_P = 64'h40;
        e_dstE = 4'h4; e_Val_E = 64'hDEAD;
        M_dstE = 4'h4; M_Val_E = 64'hBEEF;
        tick();
        chk_cnt++; if (E_Val_A !== 64'h40) $display("FAIL call_valA got %h want 40", E_Val_A); else pass_cnt++;
        chk_cnt++; if (E_srcA !== 4'hF) $display("FAIL call_srcA got %h want f", E_srcA); else pass_cnt++;
        chk_cnt++; if (E_dstE !== 4'h4) $display("FAIL call_dstE got %h want 4", E_dstE); else pass_cnt++;
    endtask

    task automatic test_stall();
        idle();
        set_d(4'h6, 4'h1, 4'h2);
        D_Val_C = 64'd123;
        E_tostall = 1'b1;
        tick();
        chk_cnt++; if (E_Ins_Code !== 4'h8) $display("FAIL stall1_icode got %h want 8", E_Ins_Code); else pass_cnt++;
        tick();
        chk_cnt++; if (E_Val_A !== 64'h40) $display("FAIL stall2_valA got %h want 40", E_Val_A); else pass_cnt++;
        chk_cnt++; if (E_Val_C !== 64'd0) $display("FAIL stall2_valC got %h want 0", E_Val_C); else pass_cnt++;
    endtask

    task automatic test_bubble_priority();
        idle();
        set_d(4'h6, 4'h1, 4'h2);
        D_stat = 3'd2; D_Val_C = 64'd77;
        E_tostall = 1'b1; E_toBubble = 1'b1;
        tick();
        chk_cnt++; if (E_Ins_Code !== 4'h1) $display("FAIL bubble_icode got %h want 1", E_Ins_Code); else pass_cnt++;
        chk_cnt++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'hFFFF)
            $display("FAIL bubble_ids got %h want ffff", {E_dstE, E_dstM, E_srcA, E_srcB}); else pass_cnt++;
        chk_cnt++; if ({E_stat, E_Val_C} !== 67'd0) $display("FAIL bubble_stat_valC got %h want 0", {E_stat, E_Val_C}); else pass_cnt++;
    endtask

    task automatic test_dual_write();
        idle();
        W_dstE = 4'h4; W_Val_E = 64'hAAAA;
        W_dstM = 4'h4; W_Val_M = 64'hBBBB;
        tick();
        idle();
        set_d(4'h2, 4'h4, 4'h0);
        tick();
        chk_cnt++; if (E_Val_A !== 64'hBBBB) $display("FAIL dual_write_reg4 got %h want bbbb", E_Val_A); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        idle();
        set_d(4'h2, 4'h5, 4'h0);
        W_dstE = 4'h5; W_Val_E = 64'h77;
        tick();
        chk_cnt++; if (E_Val_A !== 64'h77) $display("FAIL same_cycle_wr_rd got %h want 77", E_Val_A); else pass_cnt++;
        W_dstE = 4'hF;
        tick();
        chk_cnt++; if (E_Val_A !== 64'h77) $display("FAIL after_wr_rd got %h want 77", E_Val_A); else pass_cnt++;
    endtask

    function automatic logic [3:0] rid();
        int r;
        r = $urandom_range(0, 9);
        return (r > 7) ? 4'hF : 4'(r);
    endfunction

    task automatic test_random();
        e_t act;
        logic [3:0] sa, sb, de, dm;
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            E_toBubble = ($urandom_range(0, 9) == 0);
            E_tostall  = ($urandom_range(0, 7) == 0);
            D_stat     = 3'($urandom_range(0, 7));
            D_Ins_Code = 4'($urandom_range(0, 15));
            D_Ins_fun  = 4'($urandom_range(0, 15));
            D_rA = rid(); D_rB = rid();
            D_Val_C = {$urandom, $urandom}; D_Val_P = {$urandom, $urandom};
            e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
            e_Val_E = {$urandom, $urandom}; M_Val_E = {$urandom, $urandom};
            m_Val_M = {$urandom, $urandom}; W_Val_E = {$urandom, $urandom}; W_Val_M = {$urandom, $urandom};
            #1;
            decode_ids(D_Ins_Code, D_rA, D_rB, sa, sb, de, dm);
            chk_cnt++; if ({d_srcA, d_srcB} !== {sa, sb})
                $display("FAIL rand_src n=%0d got %h want %h", n, {d_srcA, d_srcB}, {sa, sb}); else pass_cnt++;
            tick();
            act = {E_stat, E_Ins_Code, E_Ins_fun, E_Val_C, E_Val_A, E_Val_B, E_dstE, E_dstM, E_srcA, E_srcB};
            chk_cnt++; if (act !== model_e)
                $display("FAIL rand_E n=%0d got %h want %h", n, act, model_e); else pass_cnt++;
        end
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_writeback_read();
        test_forward_priority();
        test_popq();
        test_call();
        test_stall();
        test_bubble_priority();
        test_dual_write();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
